// File: rtl/bus_snapshot_pkg.sv
// bus_snapshot_pkg: shared state encoding and sizing helpers for bus_snapshot_mux
package bus_snapshot_pkg;
  typedef enum logic {IDLE, DRAIN} state_t;
  localparam int OVR_WIDTH = 16;
  function automatic int idx_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/period_tick.sv
// period_tick: free-running 0..PERIOD-1 counter with a one-cycle tick at PERIOD-1
module period_tick #(
  parameter int PERIOD = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);
  localparam int CW = PERIOD > 1 ? $clog2(PERIOD) : 1;
  logic [CW-1:0] r_cnt;
  assign o_tick = r_cnt == CW'(PERIOD - 1);
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/bus_snapshot_mux.sv
// bus_snapshot_mux: atomic multi-channel snapshot drained as a valid/ready word stream
module bus_snapshot_mux
  import bus_snapshot_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int CHANNELS    = 4,
  parameter int EXT_TRIGGER = 0,
  parameter int PERIOD      = 1000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic                            trigger,
  input  logic [CHANNELS*WIDTH-1:0]       data_in,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [WIDTH-1:0]                m_data,
  output logic [idx_width(CHANNELS)-1:0]  m_index,
  output logic                            m_last,
  output logic                            busy,
  output logic [OVR_WIDTH-1:0]            overrun_count
);
  localparam int IW = idx_width(CHANNELS);
  state_t r_state;
  logic [WIDTH-1:0] r_shadow [CHANNELS];
  logic w_tick, w_cap_req;
  logic [IW-1:0] w_nidx;
  generate
    if (EXT_TRIGGER == 0) begin : g_tick
      period_tick #(.PERIOD(PERIOD)) u_tick (.clk(clk), .rst(rst), .o_tick(w_tick));
    end else begin : g_no_tick
      assign w_tick = 1'b0;
    end
  endgenerate
  assign w_cap_req = enable & (EXT_TRIGGER != 0 ? trigger : w_tick);
  assign w_nidx = m_index + 1'b1;
  // m_index doubles as the drain pointer; outputs are loaded one beat ahead
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      m_valid <= 1'b0;
      m_data <= '0;
      m_index <= '0;
      m_last <= 1'b0;
      busy <= 1'b0;
      overrun_count <= '0;
      for (int c = 0; c < CHANNELS; c++) r_shadow[c] <= '0;
    end else if (r_state == IDLE) begin
      if (w_cap_req) begin
        for (int c = 0; c < CHANNELS; c++) r_shadow[c] <= data_in[c*WIDTH +: WIDTH];
        m_data <= data_in[WIDTH-1:0];
        m_index <= '0;
        m_last <= CHANNELS == 1;
        m_valid <= 1'b1;
        busy <= 1'b1;
        r_state <= DRAIN;
      end
    end else begin
      if (w_cap_req && overrun_count != '1) overrun_count <= overrun_count + 1'b1;
      if (m_ready) begin
        if (m_last) begin
          m_valid <= 1'b0;
          busy <= 1'b0;
          r_state <= IDLE;
        end else begin
          m_index <= w_nidx;
          m_data <= r_shadow[w_nidx];
          m_last <= w_nidx == IW'(CHANNELS - 1);
        end
      end
    end
  end
endmodule

// File: tb/tb_bus_snapshot_mux.sv
// tb_bus_snapshot_mux: scoreboard bench for trigger-mode and tick-mode snapshot streams
module tb_bus_snapshot_mux;
  typedef struct {logic [63:0] d; logic [1:0] i; logic l; int cyc;} ent_t;
  logic clk = 0, rst = 1;
  logic a_en = 1, a_trig = 0, a_ready = 1, a_valid, a_last, a_busy;
  logic b_en = 0, b_ready = 1, b_valid, b_last, b_busy;
  logic [255:0] a_din = '0, b_din = '0, dx, dy;
  logic [63:0] a_data, b_data;
  logic [1:0] a_index, b_index;
  logic [15:0] a_ovr, b_ovr;
  ent_t qa[$], qb[$];
  ent_t ea, eb;
  int total = 0, bad = 0, bn = 0, nb;
  always #5 clk = ~clk;
  bus_snapshot_mux #(.WIDTH(64), .CHANNELS(4), .EXT_TRIGGER(1), .PERIOD(10)) u_a (
    .clk(clk), .rst(rst), .enable(a_en), .trigger(a_trig), .data_in(a_din),
    .m_valid(a_valid), .m_ready(a_ready), .m_data(a_data), .m_index(a_index),
    .m_last(a_last), .busy(a_busy), .overrun_count(a_ovr));
  bus_snapshot_mux #(.WIDTH(64), .CHANNELS(4), .EXT_TRIGGER(0), .PERIOD(10)) u_b (
    .clk(clk), .rst(rst), .enable(b_en), .trigger(1'b0), .data_in(b_din),
    .m_valid(b_valid), .m_ready(b_ready), .m_data(b_data), .m_index(b_index),
    .m_last(b_last), .busy(b_busy), .overrun_count(b_ovr));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [255:0] d, input int cyc, input bit to_b);
    for (int c = 0; c < 4; c++) begin
      ent_t e;
      e.d = d[c*64 +: 64];
      e.i = 2'(c);
      e.l = c == 3;
      e.cyc = cyc + c;
      if (to_b) qb.push_back(e);
      else qa.push_back(e);
    end
  endtask
  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int c = 0; c < 8; c++) r[c*32 +: 32] = $urandom;
    return r;
  endfunction
  task automatic wait_idle_a();
    int k = 0;
    @(negedge clk);
    while (a_valid && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("a_drain_done", {63'b0, a_valid}, 64'd0);
    check("a_q_empty", 64'(qa.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask
  task automatic count_beats(input bool_scramble, output int n);
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n += int'(a_valid);
      @(posedge clk);
      #1;
      if (bool_scramble) a_din = rnd256();
    end
  endtask
  always @(negedge clk) begin
    if (!rst && a_valid && a_ready) begin
      if (qa.size() == 0) check("a_extra", {63'b0, a_valid}, 64'd0);
      else begin
        ea = qa.pop_front();
        check("a_data", a_data, ea.d);
        check("a_idx", 64'(a_index), 64'(ea.i));
        check("a_last", 64'(a_last), 64'(ea.l));
      end
    end
  end
  always @(negedge clk) begin
    if (!rst && b_valid && b_ready) begin
      if (qb.size() == 0) check("b_extra", {63'b0, b_valid}, 64'd0);
      else begin
        eb = qb.pop_front();
        check("b_data", b_data, eb.d);
        check("b_idx", 64'(b_index), 64'(eb.i));
        check("b_last", 64'(b_last), 64'(eb.l));
        check("b_cyc", 64'(bn), 64'(eb.cyc));
      end
    end
  end
  initial begin
    dx = {64'h44, 64'h33, 64'h22, 64'h11};
    dy = {64'hD4, 64'hC3, 64'hB2, 64'hA1};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {63'b0, a_valid}, 64'd0);
    check("rst_busy", {63'b0, a_busy}, 64'd0);
    check("rst_data", a_data, 64'd0);
    check("rst_idx", 64'(a_index), 64'd0);
    check("rst_last", 64'(a_last), 64'd0);
    check("rst_ovr", 64'(a_ovr), 64'd0);
    check("rst_b_valid", {63'b0, b_valid}, 64'd0);
    @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk);
    #1;
    // single pulse: 4 beats, 1-cycle latency
    a_din = dx;
    a_trig = 1;
    push(dx, 0, 0);
    @(negedge clk);
    check("a_lat0", {63'b0, a_valid}, 64'd0);
    @(posedge clk);
    #1;
    a_trig = 0;
    count_beats(0, nb);
    check("a_beats1", 64'(nb), 64'd4);
    check("a_q_empty1", 64'(qa.size()), 64'd0);
    // data scrambled after the capture edge
    a_din = dx;
    a_trig = 1;
    push(dx, 0, 0);
    @(posedge clk);
    #1;
    a_trig = 0;
    a_din = rnd256();
    count_beats(1, nb);
    check("a_beats2", 64'(nb), 64'd4);
    check("a_q_empty2", 64'(qa.size()), 64'd0);
    // backpressure on beat 2
    a_din = dx;
    a_trig = 1;
    push(dx, 0, 0);
    @(posedge clk);
    #1;
    a_trig = 0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    a_ready = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid", {63'b0, a_valid}, 64'd1);
      check("stall_data", a_data, 64'h33);
      check("stall_idx", 64'(a_index), 64'd2);
      @(posedge clk);
      #1;
    end
    a_ready = 1;
    wait_idle_a();
    // overruns during drain, including the last-beat handshake cycle
    for (int k = 0; k < 6; k++) begin
      a_trig = k != 2;
      if (k == 0) push(dx, 0, 0);
      if (k == 1) a_din = dy;
      if (k == 5) push(dy, 0, 0);
      @(negedge clk);
      if (k == 4) check("ovr_busy_last", {63'b0, a_busy}, 64'd1);
      if (k == 5) check("ovr_idle_gap", {63'b0, a_valid}, 64'd0);
      @(posedge clk);
      #1;
    end
    a_trig = 0;
    check("ovr_count", 64'(a_ovr), 64'd3);
    wait_idle_a();
    check("ovr_count_hold", 64'(a_ovr), 64'd3);
    // reset during the first beat
    a_trig = 1;
    @(posedge clk);
    #1;
    a_trig = 0;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    check("mid_rst_valid", {63'b0, a_valid}, 64'd0);
    check("mid_rst_busy", {63'b0, a_busy}, 64'd0);
    check("mid_rst_ovr", 64'(a_ovr), 64'd0);
    repeat (10) @(negedge clk);
    check("mid_rst_quiet", {63'b0, a_valid}, 64'd0);
    // tick mode: realign counter with a fresh reset
    @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    for (int n = 0; n < 76; n++) begin
      bn = n;
      b_en = n < 25 || n >= 47;
      b_din = rnd256();
      if (n % 10 == 9 && b_en) push(b_din, n + 1, 1);
      @(posedge clk);
      #1;
    end
    b_en = 0;
    check("b_q_empty", 64'(qb.size()), 64'd0);
    check("b_ovr", 64'(b_ovr), 64'd0);
    check("b_idle_end", {63'b0, b_valid}, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_snapshot_mux.md
Name: bus_snapshot_mux

Overview:
- Single-clock, multi-channel successor to the handshake bus-capture stage.
- Captures CHANNELS parallel buses atomically into a shadow bank, either on an external trigger or on a periodic internal tick.
- Drains the shadow bank as a valid/ready stream, one channel word per beat, tagged with channel index and last flag.
- Sits between the statistics counters and the DMA/AXI-stream packer.

Parameters:
- WIDTH, 64, bits per channel word.
- CHANNELS, 4, number of captured buses (1..64).
- EXT_TRIGGER, 0, 1 = capture on trigger pulses; 0 = capture on internal period tick.
- PERIOD, 1000, clk cycles between internal ticks (used only when EXT_TRIGGER=0; min 1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- enable  in  1  gates all new captures; an in-progress drain always completes
- trigger  in  1  capture request, sampled every cycle; ignored when EXT_TRIGGER=0
- data_in  in  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- m_valid  out  1  output word valid
- m_ready  in  1  consumer accept
- m_data  out  WIDTH  shadow word for channel m_index
- m_index  out  $clog2(CHANNELS) (min 1)  channel number of current word
- m_last  out  1  high on the beat carrying channel CHANNELS-1
- busy  out  1  capture held / drain in progress
- overrun_count  out  16  captures dropped because busy was high; saturates at 0xFFFF

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: m_valid=0, m_index=0, m_last=0, m_data=0, busy=0, overrun_count=0. Shadow bank and tick counter are cleared. State returns to IDLE.
- Reset mid-drain discards the remaining words; no partial stream resumes afterwards.
- cap_req:
  - EXT_TRIGGER=1: cap_req = trigger & enable.
  - EXT_TRIGGER=0: cap_req = tick & enable. A free-running counter counts 0..PERIOD-1 and tick is high for the single cycle at PERIOD-1. The counter runs regardless of enable.
- State machine, IDLE:
  - m_valid=0, busy=0.
  - On cap_req, all CHANNELS words of data_in are written to the shadow bank in the same edge (atomic snapshot). Go to DRAIN with ptr=0.
- State machine, DRAIN:
  - m_valid=1, busy=1, m_data=shadow[ptr], m_index=ptr, m_last=(ptr==CHANNELS-1).
  - On m_valid & m_ready: if m_last, go to IDLE; else ptr++.
  - Outputs are registered. The first beat is visible the cycle after the capture edge, so capture-to-first-valid latency is 1 cycle.
- AXI-stream rules:
  - m_data, m_index and m_last are stable while m_valid & ~m_ready.
  - m_valid never drops without a handshake.
- Throughput: with m_ready held high, a full drain takes CHANNELS cycles. The block returns to IDLE on the edge after the last beat is accepted.
- Simultaneous events:
  - cap_req in the same cycle as the last-beat handshake is dropped and counted as an overrun; busy is still 1 that cycle.
  - The next capture is possible from the first IDLE cycle.
- Overrun: cap_req while in DRAIN does not alter the shadow bank. overrun_count increments by 1 and saturates.
- CHANNELS=1: m_last is always 1 during DRAIN and m_index is 0.
- enable falling mid-drain has no effect on the drain.

Decomposition:
- Package bus_snapshot_pkg holds:
  - state enum (IDLE, DRAIN);
  - function idx_width(n) = max(1, $clog2(n));
  - localparam OVR_WIDTH=16.
- Sub-module period_tick (counter plus single-cycle tick, parameter PERIOD) is instantiated only when EXT_TRIGGER=0.

Test Plan:
- EXT_TRIGGER=1, CHANNELS=4, m_ready=1, data_in = {0x44,0x33,0x22,0x11}, single trigger pulse -> m_valid high for exactly 4 cycles starting 1 cycle after the trigger, data 0x11,0x22,0x33,0x44, index 0..3, m_last only on 0x44.
- Same setup, data_in changed every cycle after the trigger -> output is still 0x11..0x44, proving the snapshot is atomic.
- m_ready low for 5 cycles on beat 2 -> m_data=0x33 and m_index=2 held stable, m_valid stays high, stream resumes correctly.
- Trigger pulses at drain beats 1 and 3 plus on the last-beat handshake cycle -> overrun_count=3 and one stream only. A trigger on the next idle cycle -> new stream.
- EXT_TRIGGER=0, PERIOD=10, m_ready=1, enable=1 -> captures every 10 cycles. Drop enable at cycle 25 -> no further streams and the tick counter keeps running. Re-enable -> captures realign to the tick.
- Assert rst during beat 1 of a drain -> next cycle m_valid=0, busy=0, overrun_count=0, and no stray beats afterwards.
